// File: rtl/cmp_rs.sv
// rtl/cmp_rs.sv - reservation station feeding the branch-compare unit
// Holds issued compares, snoops the CDB for pending operands, exposes ready lanes.
module cmp_rs #(
   parameter int size = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     issue_valid,
   input  logic [2:0]               issue_op,
   input  logic [3:0]               issue_tag,
   input  logic [31:0]              issue_r1,
   input  logic [31:0]              issue_r2,
   input  logic                     issue_r1_valid,
   input  logic                     issue_r2_valid,
   input  logic [3:0]               issue_q1,
   input  logic [3:0]               issue_q2,
   input  logic                     cdb_valid,
   input  logic [3:0]               cdb_tag,
   input  logic [31:0]              cdb_data,
   input  logic [size-1:0]          lane_ack,
   output logic                     full,
   output logic [$clog2(size):0]    count,
   output logic [size-1:0]          lane_ready,
   output logic [size*3-1:0]        lane_op,
   output logic [size*32-1:0]       lane_r1,
   output logic [size*32-1:0]       lane_r2,
   output logic [size*4-1:0]        lane_tag
);

   localparam int cw = $clog2(size) + 1;

   logic [size-1:0]        busy_q;
   logic [size-1:0]        v1_q;
   logic [size-1:0]        v2_q;
   logic [size-1:0][2:0]   op_q;
   logic [size-1:0][3:0]   tag_q;
   logic [size-1:0][3:0]   q1_q;
   logic [size-1:0][3:0]   q2_q;
   logic [size-1:0][31:0]  r1_q;
   logic [size-1:0][31:0]  r2_q;

   logic [size-1:0]        alloc_oh;
   logic                   found;
   logic                   accept;
   logic                   fwd1;
   logic                   fwd2;
   logic [cw-1:0]          count_c;

   // lowest-index free entry, taken from the registered busy set
   always_comb begin
      alloc_oh = '0;
      found    = 1'b0;
      for (int i = 0; i < size; i++) begin
         if (!busy_q[i] && !found) begin
            alloc_oh[i] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   always_comb begin
      count_c = '0;
      for (int i = 0; i < size; i++) begin
         count_c = count_c + cw'(busy_q[i]);
      end
   end

   assign full   = &busy_q;
   assign count  = count_c;
   assign accept = issue_valid & ~full;
   assign fwd1   = ~issue_r1_valid & cdb_valid & (cdb_tag == issue_q1);
   assign fwd2   = ~issue_r2_valid & cdb_valid & (cdb_tag == issue_q2);

   assign lane_ready = busy_q & v1_q & v2_q;

   always_comb begin
      lane_op  = '0;
      lane_r1  = '0;
      lane_r2  = '0;
      lane_tag = '0;
      for (int i = 0; i < size; i++) begin
         lane_op[i*3 +: 3]   = op_q[i];
         lane_r1[i*32 +: 32] = r1_q[i];
         lane_r2[i*32 +: 32] = r2_q[i];
         lane_tag[i*4 +: 4]  = tag_q[i];
      end
   end

   // flush beats issue, snoop and ack; an allocating entry is never busy so it cannot be acked
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= '0;
         v1_q   <= '0;
         v2_q   <= '0;
         op_q   <= '0;
         tag_q  <= '0;
         q1_q   <= '0;
         q2_q   <= '0;
         r1_q   <= '0;
         r2_q   <= '0;
      end else if (flush) begin
         busy_q <= '0;
         v1_q   <= '0;
         v2_q   <= '0;
      end else begin
         for (int i = 0; i < size; i++) begin
            if (accept && alloc_oh[i]) begin
               busy_q[i] <= 1'b1;
               op_q[i]   <= issue_op;
               tag_q[i]  <= issue_tag;
               q1_q[i]   <= issue_q1;
               q2_q[i]   <= issue_q2;
               r1_q[i]   <= fwd1 ? cdb_data : issue_r1;
               r2_q[i]   <= fwd2 ? cdb_data : issue_r2;
               v1_q[i]   <= issue_r1_valid | fwd1;
               v2_q[i]   <= issue_r2_valid | fwd2;
            end else if (busy_q[i] && lane_ack[i] && lane_ready[i]) begin
               busy_q[i] <= 1'b0;
            end else if (busy_q[i] && cdb_valid) begin
               if (!v1_q[i] && (q1_q[i] == cdb_tag)) begin
                  r1_q[i] <= cdb_data;
                  v1_q[i] <= 1'b1;
               end
               if (!v2_q[i] && (q2_q[i] == cdb_tag)) begin
                  r2_q[i] <= cdb_data;
                  v2_q[i] <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: doc/cmp_rs.md
# cmp_rs

Reservation station for the branch-compare functional unit. Holds up to `size` issued compare operations, snoops the common data bus (CDB) for outstanding source operands, and presents every entry with both operands resolved as a ready lane to the downstream `cmp` unit. Entries are freed when the CDB arbiter acknowledges their lane's result.

## Interface
- `size`, 8: number of entries/lanes; must match the downstream comparator's lane count.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous clear of all entries (mispredict recovery).
- `issue_valid`  in  1  issue request this cycle.
- `issue_op`  in  3  compare op, funct3 encoding: beq 000, bne 001, blt 100, bge 101, bltu 110, bgeu 111.
- `issue_tag`  in  4  ROB tag of the instruction.
- `issue_r1`, `issue_r2`  in  32  source values; meaningful only when the matching `_valid` is 1.
- `issue_r1_valid`, `issue_r2_valid`  in  1  source value already available.
- `issue_q1`, `issue_q2`  in  4  producer ROB tag when the source is not valid.
- `cdb_valid`  in  1  CDB broadcast valid.
- `cdb_tag`  in  4  CDB producer tag.
- `cdb_data`  in  32  CDB value.
- `lane_ack`  in  size  per-lane acceptance of the comparator result by the CDB arbiter.
- `full`  out  1  no free entry.
- `count`  out  $clog2(size)+1  number of occupied entries.
- `lane_ready`  out  size  entry occupied and both operands valid.
- `lane_op`  out  size x 3  per-lane op.
- `lane_r1`, `lane_r2`  out  size x 32  per-lane operands.
- `lane_tag`  out  size x 4  per-lane ROB tag.

## Operation
- Per-entry state: `busy`, op, tag, r1/r2 values, r1/r2 valid bits, q1/q2 producer tags.
- Allocation: an accepted issue goes to the lowest-index entry that is not busy. Issue is accepted only when `issue_valid` is 1 and `full` is 0. Issue while `full` is silently dropped, so upstream must gate on `full`.
- Issue-time forwarding: if an issued operand is not valid, `cdb_valid` is 1 and `cdb_tag` equals its q, the entry is written with the CDB value and that operand's valid bit set.
- CDB snoop: every busy entry with an invalid operand whose q equals `cdb_tag` while `cdb_valid` is 1 captures `cdb_data` and sets that valid bit. Both operands may capture from the same broadcast.
- `lane_ready[i]` = busy & r1_valid & r2_valid. This is combinational from registered state.
- `lane_op`, `lane_r1`, `lane_r2` and `lane_tag` are driven straight from the entry; they are undefined when the lane is not ready.
- Free: `lane_ack[i]` with `lane_ready[i]` clears busy at the edge. `lane_ack` on a non-ready lane is ignored.
- `full` and `count` are computed from registered busy bits. A slot freed at edge t becomes allocatable from edge t+1.
- `flush`: all busy and valid bits are cleared at the edge. It overrides issue, CDB capture and ack in the same cycle.

## Timing
- Reset (async assert, any time, including mid-operation): all busy and valid bits go to 0 immediately. Outputs then read `lane_ready`=0, `full`=0, `count`=0; lane data buses read 0.
- Issue with both operands valid at edge t: `lane_ready` is high from t+1. Minimum latency from issue to lane ready is 1 cycle.
- CDB capture at edge t: the lane becomes ready from t+1 if the other operand is already valid.
- Ack sampled at edge t: `lane_ready` is low and the entry is free from t+1, and `count` decrements at t+1.
- Ack and CDB on the same entry in the same cycle: ack wins and the entry is freed. This cannot occur legally, because ack requires ready.
- Issue and ack in the same cycle: both take effect, `count` is unchanged, and allocation uses the pre-edge free set.
- Multiple acks in one cycle are all honoured.
- Busy entries hold indefinitely until acked or flushed; there is no timeout.

## Test plan
- Reset, then issue beq, tag 3, r1=r2=5, both valid -> at the next cycle `lane_ready`=0000_0001, `lane_tag[0]`=3, `count`=1. Ack lane 0 -> the following cycle `lane_ready`=0, `count`=0.
- Issue blt, tag 2, r1 waiting on q1=7, r2=1 valid -> lane 0 is not ready. CDB tag 7, data 0xFFFF_FFFF -> next cycle lane 0 is ready with `lane_r1`=0xFFFF_FFFF.
- Issue bne with q1=q2=9 while `cdb_valid` is 1, `cdb_tag`=9, data 4 in the same cycle -> next cycle ready with r1=r2=4.
- Fill all 8 entries -> `full`=1 and `count`=8. A further issue is dropped. Ack lane 5 together with an issue -> the new op is dropped this cycle because `full` was 1. Issue next cycle lands in entry 5.
- With 4 busy entries, assert `flush` together with an issue -> next cycle `count`=0 and `lane_ready`=0.
- Assert `rst` low asynchronously mid-cycle with 3 ready entries -> `lane_ready`=0 and `count`=0 before the next clock edge.
